// File: rtl/proc_seq_pkg.sv
// Shared types and constants for the multicycle phase sequencer:
// state encoding, opcode/ALU-op decodes, writeback select and status codes.
package proc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_STAT = 2'd2;

  localparam logic [1:0] ST_NONE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_ADDI = 2'd2;
  localparam logic [1:0] ST_SUB  = 2'd3;

  // Status code for an overflowing add/sub/addi; ST_NONE otherwise.
  function automatic logic [1:0] ovf_status(
    input logic [4:0] op,
    input logic [4:0] aop,
    input logic       ovf
  );
    logic [1:0] st;
    st = ST_NONE;
    if (ovf) begin
      if (op == OP_ADDI)
        st = ST_ADDI;
      else if (op == OP_R && aop == ALU_ADD)
        st = ST_ADD;
      else if (op == OP_R && aop == ALU_SUB)
        st = ST_SUB;
    end
    return st;
  endfunction

endpackage

// File: rtl/proc_phase_sequencer.sv
// Multicycle control sequencer: steps FETCH/DECODE/EXEC/MEM/WB, steers
// writeback (ALU, dmem or overflow status to $r30) and counts retirements.
// Ports: clock, ctrl_reset (async, active-low), run, opcode, alu_op, ovf in;
// per-phase enables, rf_wsel/rf_wr30/status_code, illegal, halted, busy,
// instr_count out.
module proc_phase_sequencer
  import proc_seq_pkg::*;
#(
  parameter int         CNT_W   = 32,
  parameter logic [4:0] HALT_OP = 5'b11111
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic [4:0]       alu_op,
  input  logic             ovf,
  output logic             imem_en,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_re,
  output logic             alu_en,
  output logic             dmem_we,
  output logic             dmem_re,
  output logic             rf_we,
  output logic [1:0]       rf_wsel,
  output logic             rf_wr30,
  output logic [1:0]       status_code,
  output logic             illegal,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  logic             r_is_lw;
  logic [1:0]       r_wsel;
  logic             r_wr30;
  logic [1:0]       r_status;
  logic             r_illegal;
  logic [CNT_W-1:0] r_count;

  logic       w_op_alu;
  logic       w_op_mem;
  logic       w_op_halt;
  logic [1:0] w_status;
  state_t     w_bnd;

  assign w_op_alu  = (opcode == OP_R) || (opcode == OP_ADDI);
  assign w_op_mem  = (opcode == OP_SW) || (opcode == OP_LW);
  assign w_op_halt = (opcode == HALT_OP);
  assign w_status  = ovf_status(opcode, alu_op, ovf);
  // run is only consulted at instruction boundaries
  assign w_bnd     = run ? S_FETCH : S_IDLE;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      r_state   <= S_IDLE;
      r_is_lw   <= 1'b0;
      r_wsel    <= WSEL_ALU;
      r_wr30    <= 1'b0;
      r_status  <= ST_NONE;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (run)
            r_state <= S_FETCH;
        end
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          r_is_lw  <= (opcode == OP_LW);
          r_status <= w_status;
          r_wr30   <= (w_status != ST_NONE);
          if (opcode == OP_LW)
            r_wsel <= WSEL_MEM;
          else if (w_status != ST_NONE)
            r_wsel <= WSEL_STAT;
          else
            r_wsel <= WSEL_ALU;
          unique case (1'b1)
            w_op_alu:  r_state <= S_WB;
            w_op_mem:  r_state <= S_MEM;
            w_op_halt: r_state <= S_HALT;
            default: begin
              r_illegal <= 1'b1;
              r_state   <= w_bnd;
            end
          endcase
        end
        S_MEM: begin
          if (r_is_lw) begin
            r_state <= S_WB;
          end else begin
            r_count <= r_count + ONE;
            r_state <= w_bnd;
          end
        end
        S_WB: begin
          r_count <= r_count + ONE;
          r_state <= w_bnd;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_en     = (r_state == S_FETCH);
  assign ir_we       = (r_state == S_DECODE);
  assign pc_we       = (r_state == S_DECODE);
  assign rf_re       = (r_state == S_DECODE);
  assign alu_en      = (r_state == S_EXEC);
  assign dmem_we     = (r_state == S_MEM) && !r_is_lw;
  assign dmem_re     = (r_state == S_MEM) && r_is_lw;
  assign rf_we       = (r_state == S_WB);
  assign halted      = (r_state == S_HALT);
  assign busy        = (r_state != S_IDLE) && (r_state != S_HALT);
  assign rf_wsel     = r_wsel;
  assign rf_wr30     = r_wr30;
  assign status_code = r_status;
  assign illegal     = r_illegal;
  assign instr_count = r_count;

endmodule

// File: tb/tb_proc_phase_sequencer.sv
// Directed bench for proc_phase_sequencer: walks each instruction class
// through its phases and checks enables, steering, sticky flags and count.
module tb_proc_phase_sequencer;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        run;
  logic [4:0]  opcode;
  logic [4:0]  alu_op;
  logic        ovf;
  logic        imem_en, ir_we, pc_we, rf_re, alu_en;
  logic        dmem_we, dmem_re, rf_we;
  logic [1:0]  rf_wsel;
  logic        rf_wr30;
  logic [1:0]  status_code;
  logic        illegal, halted, busy;
  logic [31:0] instr_count;

  int errors = 0;
  int checks = 0;

  // {imem_en, ir_we, pc_we, rf_re, alu_en, dmem_we, dmem_re, rf_we, halted, busy}
  localparam logic [9:0] P_IDLE  = 10'b0000000000;
  localparam logic [9:0] P_FETCH = 10'b1000000001;
  localparam logic [9:0] P_DEC   = 10'b0111000001;
  localparam logic [9:0] P_EXEC  = 10'b0000100001;
  localparam logic [9:0] P_MEMW  = 10'b0000010001;
  localparam logic [9:0] P_MEMR  = 10'b0000001001;
  localparam logic [9:0] P_WB    = 10'b0000000101;
  localparam logic [9:0] P_HALT  = 10'b0000000010;

  proc_phase_sequencer #(.CNT_W(32), .HALT_OP(5'b11111)) dut (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .run         (run),
    .opcode      (opcode),
    .alu_op      (alu_op),
    .ovf         (ovf),
    .imem_en     (imem_en),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .rf_re       (rf_re),
    .alu_en      (alu_en),
    .dmem_we     (dmem_we),
    .dmem_re     (dmem_re),
    .rf_we       (rf_we),
    .rf_wsel     (rf_wsel),
    .rf_wr30     (rf_wr30),
    .status_code (status_code),
    .illegal     (illegal),
    .halted      (halted),
    .busy        (busy),
    .instr_count (instr_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ph(input string tag, input logic [9:0] exp);
    chk(tag, {22'd0, imem_en, ir_we, pc_we, rf_re, alu_en,
              dmem_we, dmem_re, rf_we, halted, busy}, {22'd0, exp});
  endtask

  task automatic chk_steer(input string tag, input logic [1:0] wsel,
                           input logic wr30, input logic [1:0] st);
    chk(tag, {27'd0, rf_wsel, rf_wr30, status_code},
             {27'd0, wsel, wr30, st});
  endtask

  initial begin
    ctrl_reset = 1'b0;
    run        = 1'b0;
    opcode     = 5'd0;
    alu_op     = 5'd0;
    ovf        = 1'b0;
    step();
    step();
    chk_ph("reset_phase", P_IDLE);
    chk_steer("reset_steer", 2'd0, 1'b0, 2'd0);
    chk("reset_cnt", instr_count, 32'd0);
    chk("reset_ill", {31'd0, illegal}, 32'd0);
    ctrl_reset = 1'b1;
    step();
    chk_ph("idle_norun", P_IDLE);

    // R-type add, no overflow
    run = 1'b1;
    step(); chk_ph("r_fetch", P_FETCH);
    step(); chk_ph("r_dec", P_DEC);
    opcode = 5'b00000; alu_op = 5'b00000; ovf = 1'b0;
    step(); chk_ph("r_exec", P_EXEC);
    step(); chk_ph("r_wb", P_WB);
    chk_steer("r_steer", 2'd0, 1'b0, 2'd0);
    chk("r_cnt_wb", instr_count, 32'd0);
    step(); chk_ph("r_next", P_FETCH);
    chk("r_cnt", instr_count, 32'd1);

    // lw: 5 cycles
    step(); opcode = 5'b01000;
    step(); chk_ph("lw_exec", P_EXEC);
    step(); chk_ph("lw_mem", P_MEMR);
    chk_steer("lw_steer", 2'd1, 1'b0, 2'd0);
    step(); chk_ph("lw_wb", P_WB);
    chk("lw_cnt_wb", instr_count, 32'd1);
    step(); chk_ph("lw_next", P_FETCH);
    chk("lw_cnt", instr_count, 32'd2);

    // sw: 4 cycles, retires in MEM
    step(); opcode = 5'b00111;
    step();
    step(); chk_ph("sw_mem", P_MEMW);
    step(); chk_ph("sw_next", P_FETCH);
    chk("sw_cnt", instr_count, 32'd3);

    // addi with overflow
    step(); opcode = 5'b00101; ovf = 1'b1;
    step();
    step(); chk_ph("addi_wb", P_WB);
    chk_steer("addi_steer", 2'd2, 1'b1, 2'd2);
    ovf = 1'b0;
    step(); chk("addi_cnt", instr_count, 32'd4);

    // sub with overflow
    step(); opcode = 5'b00000; alu_op = 5'b00001; ovf = 1'b1;
    step();
    step(); chk_steer("sub_steer", 2'd2, 1'b1, 2'd3);
    ovf = 1'b0;
    step();

    // add with overflow
    step(); alu_op = 5'b00000; ovf = 1'b1;
    step();
    step(); chk_steer("add_steer", 2'd2, 1'b1, 2'd1);
    ovf = 1'b0;
    step();

    // other R-type op with ovf: no status steering
    step(); alu_op = 5'b00010; ovf = 1'b1;
    step();
    step(); chk_steer("and_steer", 2'd0, 1'b0, 2'd0);
    ovf = 1'b0;
    step(); chk("ovf_cnt", instr_count, 32'd7);

    // drop run in DECODE
    step(); chk_ph("drop_dec", P_DEC);
    run = 1'b0; alu_op = 5'b00000;
    step(); chk_ph("drop_exec", P_EXEC);
    step(); chk_ph("drop_wb", P_WB);
    step(); chk_ph("drop_idle", P_IDLE);
    chk("drop_cnt", instr_count, 32'd8);
    step(); chk_ph("drop_idle2", P_IDLE);
    run = 1'b1;
    step(); chk_ph("resume", P_FETCH);

    // illegal opcode: 3 cycles, not retired
    step(); opcode = 5'b10101;
    step(); chk_ph("ill_exec", P_EXEC);
    step(); chk_ph("ill_next", P_FETCH);
    chk("ill_flag", {31'd0, illegal}, 32'd1);
    chk("ill_cnt", instr_count, 32'd8);

    // halt
    step(); opcode = 5'b11111;
    step();
    step(); chk_ph("halt_enter", P_HALT);
    for (int i = 0; i < 20; i++) begin
      step();
      chk_ph("halt_hold", P_HALT);
    end
    chk("halt_cnt", instr_count, 32'd8);
    chk("ill_sticky", {31'd0, illegal}, 32'd1);

    // async reset mid-MEM of sw
    ctrl_reset = 1'b0;
    step();
    ctrl_reset = 1'b1;
    step(); chk_ph("rst2_fetch", P_FETCH);
    step(); opcode = 5'b00111;
    step();
    step(); chk_ph("rst2_mem", P_MEMW);
    #2 ctrl_reset = 1'b0;
    #1;
    chk_ph("async_phase", P_IDLE);
    chk_steer("async_steer", 2'd0, 1'b0, 2'd0);
    chk("async_cnt", instr_count, 32'd0);
    chk("async_ill", {31'd0, illegal}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/proc_phase_sequencer.md
# proc_phase_sequencer

Multicycle control sequencer for the simple processor datapath: steps the imem, regfile, ALU and dmem through fetch, decode, execute, memory and writeback phases. It also steers writeback and counts retired instructions. It sits between the top-level `clock`/`ctrl_reset` and the datapath enables, and replaces the free-running per-unit clock dividers.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `HALT_OP`, 5'b11111: opcode that halts the sequencer.
- `clock`  in  1: sole clock; all state updates on posedge.
- `ctrl_reset`  in  1: asynchronous, active-low reset.
- `run`  in  1: level; 1 = execute, 0 = stop at next instruction boundary.
- `opcode`  in  5: IR[31:27]; valid from EXEC onward.
- `alu_op`  in  5: IR[6:2]; valid from EXEC onward.
- `ovf`  in  1: ALU overflow; sampled on the last edge of EXEC.
- `imem_en`  out  1: imem read enable (FETCH).
- `ir_we`, `pc_we`, `rf_re`  out  1 each: IR capture, PC+1 update and regfile read (DECODE).
- `alu_en`  out  1: ALU operand/result latch (EXEC).
- `dmem_we`, `dmem_re`  out  1 each: dmem write (sw) and read (lw) in MEM.
- `rf_we`  out  1: regfile write (WB).
- `rf_wsel`  out  2: 0 = ALU, 1 = dmem, 2 = status value; valid in WB.
- `rf_wr30`  out  1: force write destination to $r30 (status).
- `illegal`  out  1: sticky; an unknown opcode was seen.
- `halted`  out  1: sequencer is in HALT.
- `busy`  out  1: state is neither IDLE nor HALT.
- `instr_count`  out  CNT_W: number of retired instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE: go to FETCH when `run`=1; otherwise stay.
- FETCH to DECODE to EXEC are unconditional.
- EXEC is decided by `opcode`:
  - 00000 (R) or 00101 (addi): go to WB.
  - 00111 (sw) or 01000 (lw): go to MEM.
  - `HALT_OP`: go to HALT.
  - Anything else: set `illegal`, go to boundary; the instruction is not retired.
- MEM: lw goes to WB; sw retires here and goes to boundary.
- WB: retires and goes to boundary.
- Boundary rule: go to FETCH if `run`=1, else IDLE.
- HALT is absorbing; it exits only through reset.
- `run` is checked only at the boundary; deasserting it mid-instruction never aborts the instruction.
- Overflow steering:
  - In EXEC, if `ovf`=1 and the instruction is R-type add (`alu_op` 00000), R-type sub (00001) or addi, latch a status code: 1 for add, 2 for addi, 3 for sub.
  - The following WB drives `rf_wsel`=2 and `rf_wr30`=1.
  - A non-overflow ALU instruction uses `rf_wsel`=0. lw uses `rf_wsel`=1.
- Retirement: `instr_count` increments by 1 on the retiring edge. It wraps from 2^CNT_W−1 to 0 with no flag.
- Every enable output is a Moore decode of the state register. `rf_wsel` and `rf_wr30` come from flops loaded in EXEC.

## Timing
- Reset: state IDLE; all enables 0, `rf_wsel`=0, `rf_wr30`=0, `illegal`=0, `halted`=0, `busy`=0, `instr_count`=0.
- Reset is effective immediately and asynchronously, including mid-instruction. No pending write completes.
- Cycles per instruction, FETCH to next FETCH with `run`=1:
  - R/addi: 4
  - sw: 4
  - lw: 5
  - illegal: 3
- Halt: HALT is entered 3 cycles after its FETCH. `halted`=1 from the first HALT cycle.
- The first FETCH comes one cycle after `run` is sampled high in IDLE.
- `ovf` must be stable for the last EXEC edge. It is ignored in every other state.
- Each of `dmem_we` and `rf_we` is high for exactly 1 cycle per instruction. They are never high together.

## Structure
- Shared package `proc_seq_pkg`:
  - state enum (3-bit, binary encoded)
  - opcode constants: OP_R, OP_ADDI, OP_SW, OP_LW
  - ALU op constants: ADD, SUB
  - `rf_wsel` codes
  - status codes 1/2/3
- No sub-module. The state register, output decode, steering flops and counter stay in one module (about 200 lines).

## Test plan
- Reset, then `run`=1; feed opcode 00000 with no ovf → states FETCH, DECODE, EXEC, WB; `rf_we` pulses with `rf_wsel`=0; `instr_count`=1 after 4 cycles.
- lw (01000) then sw (00111) back-to-back → lw takes 5 cycles (`dmem_re` in MEM, `rf_wsel`=1); sw takes 4 with `dmem_we` only; `instr_count`=2.
- addi with `ovf`=1 in EXEC → WB shows `rf_wsel`=2 and `rf_wr30`=1 with status code 2; sub with ovf → status code 3.
- Opcode 10101 → `illegal`=1 and stays 1; count unchanged; FETCH follows 3 cycles later. Then HALT_OP → `halted`=1, `busy`=0, and the state holds for 20 cycles despite `run`=1.
- Drop `run` in DECODE of an R-type → instruction completes through WB, then IDLE; raising `run` resumes FETCH on the next cycle.
- Assert `ctrl_reset`=0 asynchronously mid-MEM of sw → `dmem_we` drops immediately; all outputs return to reset values; `instr_count`=0.
